pulse_counter: RTL and testbench
================================

Name: pulse_counter

Overview:
- Up-counter that counts enabled clock cycles (heartbeat pulse qualified into `enb`) for the health monitor datapath.
- Counter value `q` feeds the rate/display logic downstream.
- Features: synchronous clear with priority over enable, wrap or saturate at full scale, terminal-count flag.

Parameters:
- WIDTH, 4, counter width in bits; `q` spans WIDTH bits, MAX = 2^WIDTH-1.
- SATURATE, 0, 0 = wrap MAX->0; 1 = hold at MAX.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous active-high clear.
- enb  input  1  count enable; one increment per rising edge while high.
- q  output  WIDTH  current count, driven directly from register.
- tc  output  1  terminal count, combinational: high when q == MAX.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- rst_n low: q = 0 immediately, independent of clk; tc = 0. Registers held while rst_n low.
- rst_n deassertion is not synchronised inside the block; the upstream reset bridge guarantees release away from the clk edge.
- Priority per rising edge, highest first:
  1. rst_n low -> q = 0.
  2. clr = 1 -> q <= 0, regardless of enb.
  3. enb = 1 -> q <= q+1.
  4. Otherwise q holds.
- Latency: q reflects an increment or clear one cycle after the sampling edge; no pipeline beyond that.
- clr held high with enb high: q stays 0 every cycle; no count leaks through.
- Wrap (SATURATE=0): q == MAX with enb=1, clr=0 -> q <= 0.
- Saturate (SATURATE=1): q == MAX with enb=1, clr=0 -> q stays MAX.
- tc follows q combinationally, with no dependence on enb.
- Arithmetic is unsigned modulo 2^WIDTH; no sign handling.
- X on enb or clr while rst_n low has no effect on q.

Optional Feature:
- Macro: PULSE_COUNTER_OVF_EN.
- Defined: adds output ovf (1 bit), a sticky flag.
  - Set on the edge where q == MAX, enb=1, clr=0 (both wrap and saturate modes).
  - Cleared by rst_n low or clr=1; clr and set on the same edge -> clr wins, ovf = 0.
  - Reset value 0.
- Undefined: ovf port and logic absent; port list exactly as above.

Test Plan:
- Reset/clear hold: rst_n=0 then 1, clr=1, enb=0 for 1 cycle -> q=0, tc=0.
- Count: clr=0, enb=1 for 5 rising edges -> q=1,2,3,4,5 after each edge.
- Clear priority: from q=5, clr=1 and enb=1 for 5 edges -> q=0 after first edge, stays 0.
- Clear, enable off: clr=1, enb=0 for 5 edges -> q=0 throughout.
- Wrap/saturate: SATURATE=0, enb=1 for 16 edges from 0 -> q=15 with tc=1, then q=0. SATURATE=1 -> q stays 15. With PULSE_COUNTER_OVF_EN, ovf=1 from the 16th edge until clr.
- Async reset mid-count: at q=7, pulse rst_n low between edges -> q=0 before next clk edge; counting resumes from 1 after release.

Source files
------------

// File: rtl/pulse_counter.sv
// Enabled-cycle up-counter with synchronous clear, wrap/saturate at full scale and terminal-count flag.
// Optional sticky overflow output `ovf` when PULSE_COUNTER_OVF_EN is defined.
module pulse_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             enb,
  output logic [WIDTH-1:0] q,
  output logic             tc
`ifdef PULSE_COUNTER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  logic             w_atMax;

  assign w_atMax = (r_count == MAX);

  // Clear outranks enable; at full scale the mode picks hold or roll to zero.
  always_comb begin
    w_next = r_count;
    if (clr) begin
      w_next = '0;
    end else if (enb) begin
      if (w_atMax && SATURATE) begin
        w_next = MAX;
      end else begin
        w_next = r_count + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign q  = r_count;
  assign tc = w_atMax;

`ifdef PULSE_COUNTER_OVF_EN
  logic r_ovf;

  // Sticky: set on any enabled edge at full scale, in either mode; clear wins on a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_ovf <= 1'b0;
    end else if (enb && w_atMax) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pulse_counter.sv
// Directed bench for pulse_counter: one wrapping and one saturating instance share stimulus.
module tb_pulse_counter;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       enb;
  logic [3:0] qWrap;
  logic [3:0] qSat;
  logic       tcWrap;
  logic       tcSat;
`ifdef PULSE_COUNTER_OVF_EN
  logic       ovfWrap;
  logic       ovfSat;
`endif

  int errors = 0;
  int checks = 0;

  pulse_counter #(.WIDTH(4), .SATURATE(1'b0)) dutWrap (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .enb   (enb),
    .q     (qWrap),
    .tc    (tcWrap)
`ifdef PULSE_COUNTER_OVF_EN
    ,
    .ovf   (ovfWrap)
`endif
  );

  pulse_counter #(.WIDTH(4), .SATURATE(1'b1)) dutSat (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .enb   (enb),
    .q     (qSat),
    .tc    (tcSat)
`ifdef PULSE_COUNTER_OVF_EN
    ,
    .ovf   (ovfSat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic clrV, input logic enbV);
    clr = clrV;
    enb = enbV;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr   = 1'bx;
    enb   = 1'bx;
    #7;
    checks++;
    if (qWrap !== 4'd0 || qSat !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_q: got %0d/%0d expected 0/0", qWrap, qSat);
    end
    checks++;
    if (tcWrap !== 1'b0 || tcSat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_tc: got %b/%b expected 0/0", tcWrap, tcSat);
    end
`ifdef PULSE_COUNTER_OVF_EN
    checks++;
    if (ovfWrap !== 1'b0 || ovfSat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ovf: got %b/%b expected 0/0", ovfWrap, ovfSat);
    end
`endif
    applyStimulus(1'b1, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (qWrap !== 4'd0 || qSat !== 4'd0 || tcWrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_clr_hold: got q=%0d/%0d tc=%b expected 0/0 tc=0", qWrap, qSat, tcWrap);
    end
  endtask

  task automatic test_count();
    applyStimulus(1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (qWrap !== 4'(i) || qSat !== 4'(i) || tcWrap !== 1'b0) begin
        errors++;
        $display("[TB] FAIL count_edge%0d: got q=%0d/%0d tc=%b expected %0d tc=0", i, qWrap, qSat, tcWrap, i);
      end
    end
  endtask

  task automatic test_clear_priority();
    applyStimulus(1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (qWrap !== 4'd0 || qSat !== 4'd0) begin
        errors++;
        $display("[TB] FAIL clr_over_enb_edge%0d: got %0d/%0d expected 0", i, qWrap, qSat);
      end
    end
  endtask

  task automatic test_clear_idle();
    applyStimulus(1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (qWrap !== 4'd0 || qSat !== 4'd0 || tcSat !== 1'b0) begin
        errors++;
        $display("[TB] FAIL clr_idle_edge%0d: got %0d/%0d expected 0", i, qWrap, qSat);
      end
    end
  endtask

  task automatic test_wrap_saturate();
    applyStimulus(1'b0, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if (qWrap !== 4'(i) || qSat !== 4'(i)) begin
        errors++;
        $display("[TB] FAIL ramp_a_edge%0d: got %0d/%0d expected %0d", i, qWrap, qSat, i);
      end
    end
    checks++;
    if (tcWrap !== 1'b1 || tcSat !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tc_at_max: got %b/%b expected 1/1", tcWrap, tcSat);
    end
`ifdef PULSE_COUNTER_OVF_EN
    checks++;
    if (ovfWrap !== 1'b0 || ovfSat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_before_wrap: got %b/%b expected 0/0", ovfWrap, ovfSat);
    end
`endif
    // Clear coincides with the full-scale enabled edge: clear must win everywhere.
    applyStimulus(1'b1, 1'b1);
    tick();
    checks++;
    if (qWrap !== 4'd0 || qSat !== 4'd0 || tcWrap !== 1'b0 || tcSat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_at_max: got q=%0d/%0d tc=%b/%b expected 0/0 tc=0/0", qWrap, qSat, tcWrap, tcSat);
    end
`ifdef PULSE_COUNTER_OVF_EN
    checks++;
    if (ovfWrap !== 1'b0 || ovfSat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_clr_wins: got %b/%b expected 0/0", ovfWrap, ovfSat);
    end
`endif
    applyStimulus(1'b0, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if (qWrap !== 4'(i) || qSat !== 4'(i)) begin
        errors++;
        $display("[TB] FAIL ramp_b_edge%0d: got %0d/%0d expected %0d", i, qWrap, qSat, i);
      end
    end
    tick();
    checks++;
    if (qWrap !== 4'd0 || tcWrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_to_zero: got q=%0d tc=%b expected 0 tc=0", qWrap, tcWrap);
    end
    checks++;
    if (qSat !== 4'd15 || tcSat !== 1'b1) begin
      errors++;
      $display("[TB] FAIL saturate_hold: got q=%0d tc=%b expected 15 tc=1", qSat, tcSat);
    end
`ifdef PULSE_COUNTER_OVF_EN
    checks++;
    if (ovfWrap !== 1'b1 || ovfSat !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_set: got %b/%b expected 1/1", ovfWrap, ovfSat);
    end
`endif
    tick();
    checks++;
    if (qWrap !== 4'd1 || qSat !== 4'd15) begin
      errors++;
      $display("[TB] FAIL post_wrap: got %0d/%0d expected 1/15", qWrap, qSat);
    end
    applyStimulus(1'b0, 1'b0);
    tick();
    checks++;
    if (qWrap !== 4'd1 || qSat !== 4'd15 || tcSat !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_idle: got %0d/%0d expected 1/15", qWrap, qSat);
    end
`ifdef PULSE_COUNTER_OVF_EN
    checks++;
    if (ovfWrap !== 1'b1 || ovfSat !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_sticky: got %b/%b expected 1/1", ovfWrap, ovfSat);
    end
`endif
    applyStimulus(1'b1, 1'b0);
    tick();
    checks++;
    if (qWrap !== 4'd0 || qSat !== 4'd0) begin
      errors++;
      $display("[TB] FAIL clr_after_wrap: got %0d/%0d expected 0/0", qWrap, qSat);
    end
`ifdef PULSE_COUNTER_OVF_EN
    checks++;
    if (ovfWrap !== 1'b0 || ovfSat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_cleared: got %b/%b expected 0/0", ovfWrap, ovfSat);
    end
`endif
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      tick();
    end
    checks++;
    if (qWrap !== 4'd7 || qSat !== 4'd7) begin
      errors++;
      $display("[TB] FAIL pre_reset_count: got %0d/%0d expected 7/7", qWrap, qSat);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (qWrap !== 4'd0 || qSat !== 4'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %0d/%0d expected 0/0", qWrap, qSat);
    end
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (qWrap !== 4'd1 || qSat !== 4'd1) begin
      errors++;
      $display("[TB] FAIL resume_after_reset: got %0d/%0d expected 1/1", qWrap, qSat);
    end
    tick();
    checks++;
    if (qWrap !== 4'd2 || qSat !== 4'd2) begin
      errors++;
      $display("[TB] FAIL resume_second: got %0d/%0d expected 2/2", qWrap, qSat);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    enb   = 1'b0;
    test_reset();
    test_count();
    test_clear_priority();
    test_clear_idle();
    test_wrap_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
